// File: rtl/i2c_pkg.sv
// Shared I2C register-bank definitions: FSM state encoding, byte width, R/W bit values.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_W_PTR  = 2'd1,
    ST_W_DATA = 2'd2,
    ST_RD     = 2'd3
  } state_t;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-stream link between the I2C peripheral (master side) and the register bank (slave side).
interface i2c_reg_bank_if;
  import i2c_pkg::*;

  logic                  rx_start;
  logic                  rx_rw;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_stop;
  logic                  rd_req;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_valid;

  modport master (
    output rx_start, rx_rw, rx_valid, rx_data, rx_stop, rd_req,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_start, rx_rw, rx_valid, rx_data, rx_stop, rd_req,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/i2c_reg_array.sv
// NUM_REGS x 8-bit register file with one masked write port and a combinational read port.
module i2c_reg_array
  import i2c_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter int          PTR_W    = 3,
  parameter logic [255:0] RO_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [PTR_W-1:0]               waddr,
  input  logic [I2C_BYTE_W-1:0]          wdata,
  input  logic [PTR_W-1:0]               raddr,
  output logic [I2C_BYTE_W-1:0]          rdata,
  output logic                           wr_ok,
  output logic [I2C_BYTE_W*NUM_REGS-1:0] flat
);

  logic [NUM_REGS-1:0][I2C_BYTE_W-1:0] regs;

  assign wr_ok = we && !RO_MASK[waddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-first bypass so a same-cycle read of the written register sees the new byte.
  assign rdata = (wr_ok && (waddr == raddr)) ? wdata : regs[raddr];
  assign flat  = regs;

endmodule

// File: rtl/i2c_reg_bank.sv
// Byte-level register bank behind the I2C peripheral: first write byte loads the pointer,
// later bytes write registers, read requests return reg[ptr]; pointer auto-increments and wraps.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int           NUM_REGS = 8,
  parameter int           PTR_W    = 3,
  parameter logic [255:0] RO_MASK  = 256'h00
) (
  input  logic                           clk,
  input  logic                           rst_n,
  i2c_reg_bank_if.slave                  bus,
  output logic [I2C_BYTE_W*NUM_REGS-1:0] reg_flat,
  output logic [I2C_BYTE_W-1:0]          led,
  output logic                           wr_stb,
  output logic [PTR_W-1:0]               wr_idx,
  output logic                           err
);

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      ptr;
  logic                  ptr_load, wr_en, rd_en, err_nxt;
  logic                  wr_ok;
  logic [I2C_BYTE_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.rx_start) begin
      state_nxt = (bus.rx_rw == RW_READ) ? ST_RD : ST_W_PTR;
    end else begin
      if (bus.rx_valid && (state == ST_W_PTR)) begin
        state_nxt = ST_W_DATA;
      end
      // A byte arriving with STOP is consumed above before the return to IDLE.
      if (bus.rx_stop) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    ptr_load = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    err_nxt  = 1'b0;
    if (bus.rx_start) begin
      err_nxt = bus.rx_valid || bus.rd_req;
    end else if (bus.rx_valid) begin
      case (state)
        ST_W_PTR:  ptr_load = 1'b1;
        ST_W_DATA: wr_en    = 1'b1;
        default:   err_nxt  = 1'b1;
      endcase
      if (bus.rd_req) begin
        err_nxt = 1'b1;
      end
    end else if (bus.rd_req) begin
      // The bus never stalls: a stray request is still served, but flagged.
      rd_en   = 1'b1;
      err_nxt = (state != ST_RD);
    end
  end

  i2c_reg_array #(
    .NUM_REGS (NUM_REGS),
    .PTR_W    (PTR_W),
    .RO_MASK  (RO_MASK)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (bus.rx_data),
    .raddr (ptr),
    .rdata (rd_data),
    .wr_ok (wr_ok),
    .flat  (reg_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      wr_stb       <= 1'b0;
      wr_idx       <= '0;
      bus.tx_data  <= '0;
      bus.tx_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (ptr_load) begin
        ptr <= bus.rx_data[PTR_W-1:0];
      end else if (wr_en || rd_en) begin
        ptr <= ptr + PTR_W'(1);
      end
      wr_stb <= wr_ok;
      if (wr_ok) begin
        wr_idx <= ptr;
      end
      bus.tx_valid <= rd_en;
      if (rd_en) begin
        bus.tx_data <= rd_data;
      end
      err <= err_nxt;
    end
  end

  assign led = reg_flat[I2C_BYTE_W-1:0];

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench: stimulus pushes expected strobes/reads/errors, negedge monitors pop and compare.
module tb_i2c_reg_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_bank_if b1 ();
  i2c_reg_bank_if b2 ();

  logic [63:0] flat1, flat2;
  logic [7:0]  led1, led2;
  logic        wr_stb1, wr_stb2, err1, err2;
  logic [2:0]  wr_idx1, wr_idx2;

  i2c_reg_bank #(.NUM_REGS(8), .PTR_W(3), .RO_MASK(256'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .reg_flat(flat1), .led(led1),
    .wr_stb(wr_stb1), .wr_idx(wr_idx1), .err(err1)
  );

  i2c_reg_bank #(.NUM_REGS(8), .PTR_W(3), .RO_MASK(256'h02)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .reg_flat(flat2), .led(led2),
    .wr_stb(wr_stb2), .wr_idx(wr_idx2), .err(err2)
  );

  int nchk = 0;
  int nfail = 0;

  logic [10:0] exp_wr1[$], exp_wr2[$];
  logic [7:0]  exp_tx1[$], exp_tx2[$];
  bit          exp_err1[$], exp_err2[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] act);
    nchk++;
    nfail++;
    $display("FAIL %s: got unexpected pulse (value %0h), expected none", nm, act);
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (wr_stb1) begin
      if (exp_wr1.size() == 0) unexpected("wr1", {5'd0, wr_idx1});
      else begin
        e = exp_wr1.pop_front();
        chk("wr1_idx", 64'(wr_idx1), 64'(e[10:8]));
        chk("wr1_dat", 64'(flat1[8*e[10:8] +: 8]), 64'(e[7:0]));
      end
    end
    if (b1.tx_valid) begin
      if (exp_tx1.size() == 0) unexpected("tx1", b1.tx_data);
      else chk("tx1_dat", 64'(b1.tx_data), 64'(exp_tx1.pop_front()));
    end
    if (err1) begin
      if (exp_err1.size() == 0) unexpected("err1", 8'd1);
      else void'(exp_err1.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (wr_stb2) begin
      if (exp_wr2.size() == 0) unexpected("wr2", {5'd0, wr_idx2});
      else begin
        e = exp_wr2.pop_front();
        chk("wr2_idx", 64'(wr_idx2), 64'(e[10:8]));
        chk("wr2_dat", 64'(flat2[8*e[10:8] +: 8]), 64'(e[7:0]));
      end
    end
    if (b2.tx_valid) begin
      if (exp_tx2.size() == 0) unexpected("tx2", b2.tx_data);
      else chk("tx2_dat", 64'(b2.tx_data), 64'(exp_tx2.pop_front()));
    end
    if (err2) begin
      if (exp_err2.size() == 0) unexpected("err2", 8'd1);
      else void'(exp_err2.pop_front());
    end
  end

  task automatic idle_inputs();
    b1.rx_start = 0; b1.rx_rw = 0; b1.rx_valid = 0; b1.rx_data = 0; b1.rx_stop = 0; b1.rd_req = 0;
    b2.rx_start = 0; b2.rx_rw = 0; b2.rx_valid = 0; b2.rx_data = 0; b2.rx_stop = 0; b2.rd_req = 0;
  endtask

  // One bus cycle of pulses on DUT d; called #1 after a rising edge.
  task automatic ev(input int d, input bit st, input bit rw, input bit vl,
                    input logic [7:0] dat, input bit sp, input bit rq);
    if (d == 1) begin
      b1.rx_start = st; b1.rx_rw = rw; b1.rx_valid = vl; b1.rx_data = dat; b1.rx_stop = sp; b1.rd_req = rq;
    end else begin
      b2.rx_start = st; b2.rx_rw = rw; b2.rx_valid = vl; b2.rx_data = dat; b2.rx_stop = sp; b2.rd_req = rq;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic start_w(input int d); ev(d, 1, 0, 0, 8'h00, 0, 0); endtask
  task automatic start_r(input int d); ev(d, 1, 1, 0, 8'h00, 0, 0); endtask
  task automatic byte_in(input int d, input logic [7:0] b); ev(d, 0, 0, 1, b, 0, 0); endtask
  task automatic stop(input int d); ev(d, 0, 0, 0, 8'h00, 1, 0); endtask
  task automatic rdreq(input int d); ev(d, 0, 0, 0, 8'h00, 0, 1); endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_flat1", flat1, 64'h0);
    chk("reset_led1", 64'(led1), 64'h0);
    chk("reset_flat2", flat2, 64'h0);
    chk("reset_tx1", 64'(b1.tx_data), 64'h0);

    // reg4 = 44, leaves ptr at 5
    start_w(1); byte_in(1, 8'h04);
    exp_wr1.push_back({3'd4, 8'h44}); byte_in(1, 8'h44); stop(1);

    // 02, AA, BB -> reg2, reg3, ptr = 4
    start_w(1); byte_in(1, 8'h02);
    exp_wr1.push_back({3'd2, 8'hAA}); byte_in(1, 8'hAA);
    exp_wr1.push_back({3'd3, 8'hBB}); byte_in(1, 8'hBB); stop(1);

    // Pointer retained across STOP: read returns reg4
    start_r(1); exp_tx1.push_back(8'h44); rdreq(1); stop(1);

    // Wrap from reg7 to reg0
    start_w(1); byte_in(1, 8'h07);
    exp_wr1.push_back({3'd7, 8'h11}); byte_in(1, 8'h11);
    exp_wr1.push_back({3'd0, 8'h22}); byte_in(1, 8'h22); stop(1);
    #3;
    chk("wrap_led", 64'(led1), 64'h22);
    chk("wrap_reg7", 64'(flat1[63:56]), 64'h11);

    // Pointer write then repeated START(R): reg1 then reg2
    start_w(1); byte_in(1, 8'h01); start_r(1);
    exp_tx1.push_back(8'h00); rdreq(1);
    exp_tx1.push_back(8'hAA); rdreq(1); stop(1);

    // RX_VALID with RD_REQ: write committed, error, no read
    start_w(1); byte_in(1, 8'h05);
    exp_wr1.push_back({3'd5, 8'h66}); exp_err1.push_back(1'b1);
    ev(1, 0, 0, 1, 8'h66, 0, 1); stop(1);

    // START with RX_VALID: byte dropped, error; next byte is the pointer
    exp_err1.push_back(1'b1); ev(1, 1, 0, 1, 8'h99, 0, 0);
    byte_in(1, 8'h06);
    exp_wr1.push_back({3'd6, 8'h77}); byte_in(1, 8'h77); stop(1);

    // RD_REQ while IDLE: served from reg7, flagged
    exp_tx1.push_back(8'h11); exp_err1.push_back(1'b1); rdreq(1);

    // RX_VALID while IDLE: ignored, flagged
    exp_err1.push_back(1'b1); byte_in(1, 8'hEE);

    // Byte together with STOP is still written
    start_w(1); byte_in(1, 8'h03);
    exp_wr1.push_back({3'd3, 8'h3C}); ev(1, 0, 0, 1, 8'h3C, 1, 0);
    exp_err1.push_back(1'b1); byte_in(1, 8'hDD);
    #3;
    chk("flat1_final", flat1, 64'h11_77_66_44_3C_AA_00_22);

    // Read-only reg1 on dut2
    start_w(2); byte_in(2, 8'h02);
    exp_wr2.push_back({3'd2, 8'h77}); byte_in(2, 8'h77); stop(2);
    start_w(2); byte_in(2, 8'h01); byte_in(2, 8'h55); stop(2);
    #3;
    chk("ro_flat2", flat2, 64'h00_00_00_00_00_77_00_00);
    #1;
    start_r(2); exp_tx2.push_back(8'h77); rdreq(2); stop(2);

    // Async reset during W_DATA, right after a committed write
    start_w(1); byte_in(1, 8'h04);
    b1.rx_valid = 1; b1.rx_data = 8'h5A;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_flat1", flat1, 64'h0);
    chk("rst_led1", 64'(led1), 64'h0);
    chk("rst_wr_stb1", 64'(wr_stb1), 64'h0);
    chk("rst_wr_idx1", 64'(wr_idx1), 64'h0);
    chk("rst_err1", 64'(err1), 64'h0);
    chk("rst_tx1", {55'd0, b1.tx_valid, b1.tx_data}, 64'h0);
    chk("rst_flat2", flat2, 64'h0);
    repeat (3) @(posedge clk);
    #1;

    chk("left_wr1", 64'(exp_wr1.size()), 64'd0);
    chk("left_tx1", 64'(exp_tx1.size()), 64'd0);
    chk("left_err1", 64'(exp_err1.size()), 64'd0);
    chk("left_wr2", 64'(exp_wr2.size()), 64'd0);
    chk("left_tx2", 64'(exp_tx2.size()), 64'd0);
    chk("left_err2", 64'(exp_err2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
